// File: rtl/mux_2to1_rr_arbiter.sv
// Round-robin 2:1 arbiter feeding a one-entry registered output stage.
// The grant pointer moves to the other channel after every transfer.
// The output register is reloaded whenever it is empty or being consumed.
module mux_2to1_rr_arbiter #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din0,
  input  logic              din0_valid,
  output logic              din0_ready,
  input  logic [DATA_W-1:0] din1,
  input  logic              din1_valid,
  output logic              din1_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              sel_q, sel_d;
  logic              prio_q, prio_d;
  logic              load_en_c;
  logic              grant_vld_c;
  logic              grant_c;

  // Next-state, grant, input handshakes and output register updates.
  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    sel_d       = sel_q;
    prio_d      = prio_q;
    grant_vld_c = 1'b0;
    grant_c     = 1'b0;
    din0_ready  = 1'b0;
    din1_ready  = 1'b0;

    // The slot can take a word when empty or when its current word leaves now.
    load_en_c = (state_q == EMPTY) | dout_ready;

    if (load_en_c) begin
      unique case ({din1_valid, din0_valid})
        2'b01: begin
          grant_vld_c = 1'b1;
          grant_c     = 1'b0;
        end
        2'b10: begin
          grant_vld_c = 1'b1;
          grant_c     = 1'b1;
        end
        2'b11: begin
          grant_vld_c = 1'b1;
          grant_c     = prio_q;
        end
        default: begin
          grant_vld_c = 1'b0;
          grant_c     = 1'b0;
        end
      endcase
    end

    din0_ready = grant_vld_c & ~grant_c;
    din1_ready = grant_vld_c & grant_c;

    unique case (state_q)
      EMPTY: begin
        if (grant_vld_c) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (dout_ready && !grant_vld_c) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase

    // A grant always loads the slot and hands priority to the other channel.
    if (grant_vld_c) begin
      dout_d = grant_c ? din1 : din0;
      sel_d  = grant_c;
      prio_d = ~grant_c;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      dout_q  <= '0;
      sel_q   <= 1'b0;
      prio_q  <= PRIO_INIT;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == FULL);
  assign sel        = sel_q;

endmodule

// File: tb/tb_mux_2to1_rr_arbiter.sv
// Bench for mux_2to1_rr_arbiter: cycle model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mux_2to1_rr_arbiter;

  localparam int unsigned DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] din0, din1, dout;
  logic              din0_valid, din1_valid, din0_ready, din1_ready;
  logic              dout_valid, dout_ready, sel;

  int n_cmp = 0;
  int n_err = 0;

  mux_2to1_rr_arbiter #(.DATA_W(DATA_W), .PRIO_INIT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din0       (din0),
    .din0_valid (din0_valid),
    .din0_ready (din0_ready),
    .din1       (din1),
    .din1_valid (din1_valid),
    .din1_ready (din1_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sel        (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the slot contents, who owns priority, and the grant rule.
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_sel;
  logic              m_prio;

  // Returns {granted, channel} for the current model state and inputs.
  function automatic logic [1:0] m_grant(input logic v0, input logic v1,
                                         input logic rdy, input logic full,
                                         input logic prio);
    logic room;
    room = !full || rdy;
    if (!room)        return 2'b00;
    if (v0 && v1)     return {1'b1, prio};
    if (v0)           return 2'b10;
    if (v1)           return 2'b11;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= 1'b0;
      m_prio  <= 1'b0;
    end else begin
      if (m_grant(din0_valid, din1_valid, dout_ready, m_valid, m_prio) == 2'b10) begin
        m_valid <= 1'b1; m_data <= din0; m_sel <= 1'b0; m_prio <= 1'b1;
      end else if (m_grant(din0_valid, din1_valid, dout_ready, m_valid, m_prio) == 2'b11) begin
        m_valid <= 1'b1; m_data <= din1; m_sel <= 1'b1; m_prio <= 1'b0;
      end else if (m_valid && dout_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] g;
    if (rst_n) begin
      g = m_grant(din0_valid, din1_valid, dout_ready, m_valid, m_prio);
      chk("model dout_valid", 32'(dout_valid), 32'(m_valid));
      chk("model dout",       32'(dout),       32'(m_data));
      chk("model sel",        32'(sel),        32'(m_sel));
      chk("model din0_ready", 32'(din0_ready), 32'(g == 2'b10));
      chk("model din1_ready", 32'(din1_ready), 32'(g == 2'b11));
    end
  end

  // Apply one cycle of inputs shortly after the rising edge.
  task automatic drive(input logic v0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [DATA_W-1:0] d1,
                       input logic rdy);
    @(posedge clk);
    #2;
    din0_valid = v0; din0 = d0;
    din1_valid = v1; din1 = d1;
    dout_ready = rdy;
  endtask

  logic [DATA_W-1:0] exp_seq [4];
  logic              exp_sel [4];

  initial begin
    int i0, i1, n_got;
    logic [4:0] kb;
    rst_n = 1'b0;
    din0 = '0; din1 = '0; din0_valid = 1'b0; din1_valid = 1'b0; dout_ready = 1'b0;
    exp_seq[0] = 8'h10; exp_seq[1] = 8'h20; exp_seq[2] = 8'h11; exp_seq[3] = 8'h21;
    exp_sel[0] = 1'b0;  exp_sel[1] = 1'b1;  exp_sel[2] = 1'b0;  exp_sel[3] = 1'b1;
    #22 rst_n = 1'b1;

    chk("reset dout_valid", 32'(dout_valid), 32'd0);
    chk("reset dout", 32'(dout), 32'd0);

    // Contention from reset priority: strict alternation starting with ch0.
    i0 = 0; i1 = 0; n_got = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1'b1, 8'(8'h10 + i0), 1'b1, 8'(8'h20 + i1), 1'b1);
      else       drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      if (k > 0) begin
        chk("contention valid", 32'(dout_valid), 32'd1);
        chk("contention dout", 32'(dout), 32'(exp_seq[k-1]));
        chk("contention sel", 32'(sel), 32'(exp_sel[k-1]));
        n_got++;
      end
      #1;
      if (din0_ready) i0++;
      if (din1_ready) i1++;
    end
    chk("contention count", 32'(n_got), 32'd4);

    // Single channel accept, 1-cycle latency.
    drive(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
    #1;
    chk("single din0_ready", 32'(din0_ready), 32'd1);
    chk("single din1_ready", 32'(din1_ready), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("single dout", 32'(dout), 32'hA5);
    chk("single sel", 32'(sel), 32'd0);
    chk("single valid", 32'(dout_valid), 32'd1);

    // Backpressure: word held, no input accepted, priority kept for ch1.
    drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'h34, 1'b1, 8'h44, 1'b0);
      #1;
      chk("stall dout", 32'(dout), 32'h33);
      chk("stall sel", 32'(sel), 32'd0);
      chk("stall din0_ready", 32'(din0_ready), 32'd0);
      chk("stall din1_ready", 32'(din1_ready), 32'd0);
    end
    drive(1'b1, 8'h34, 1'b1, 8'h44, 1'b1);
    #1;
    chk("release din1_ready", 32'(din1_ready), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("release dout", 32'(dout), 32'h44);
    chk("release sel", 32'(sel), 32'd1);

    // Back-to-back on ch1: no bubbles.
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1'b0, 8'h00, 1'b1, 8'(8'h50 + k), 1'b1);
      else       drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      if (k > 0) begin
        chk("b2b valid", 32'(dout_valid), 32'd1);
        chk("b2b dout", 32'(dout), 32'(8'h50 + k - 1));
      end
    end

    // Fairness after idle: ch1 granted alone, then ch0 wins the tie.
    drive(1'b0, 8'h00, 1'b1, 8'h60, 1'b1);
    #1;
    chk("fair din1_ready", 32'(din1_ready), 32'd1);
    drive(1'b1, 8'h70, 1'b1, 8'h61, 1'b1);
    #1;
    chk("fair din0_ready", 32'(din0_ready), 32'd1);
    chk("fair din1_ready tie", 32'(din1_ready), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("fair dout", 32'(dout), 32'h70);

    // Mixed directed pattern table, checked by the model each cycle.
    for (int k = 0; k < 32; k++) begin
      kb = 5'(k);
      drive(kb[0], 8'(8'h80 + k), kb[1] | kb[3], 8'(8'hC0 + k), kb[2] ^ kb[4]);
    end

    // Asynchronous reset while holding a word.
    drive(1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("pre-reset valid", 32'(dout_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset dout", 32'(dout), 32'd0);
    chk("async reset valid", 32'(dout_valid), 32'd0);
    chk("async reset sel", 32'(sel), 32'd0);
    #4 rst_n = 1'b1;
    drive(1'b1, 8'h12, 1'b1, 8'h34, 1'b1);
    #1;
    chk("post-reset prio", 32'(din0_ready), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
